// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a 4:1 byte multiplexer with a single-entry
// valid/ready output register fed from the multiplexer's output.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NCH = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       ch_q, ch_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       can_accept;
  logic       accept;

  // Priority scan starting at the round-robin pointer.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |req;
  assign can_accept = (state_q == EMPTY) || out_ready;
  assign accept     = can_accept && any_req && !rst;

  assign sel = any_req ? winner : ptr_q;
  assign gnt = accept ? (4'b0001 << winner) : 4'b0000;

  // Next state: accept loads a new word (drain-and-refill), otherwise drain.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (accept) begin
      state_d = FULL;
      ptr_d   = winner + 2'd1;
      data_d  = mux_out;
      ch_d    = winner;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomised scoreboard bench for rr_mux_arbiter with a behavioural
// round-robin model and a combinational 4:1 multiplexer stand-in.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] mux_out;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   m_ptr  = 0;
  bit   m_full = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mux_in(input logic [1:0] s);
    case (s)
      2'd0:    return 8'hAA;
      2'd1:    return 8'hB1;
      2'd2:    return 8'hC2;
      default: return 8'hD3;
    endcase
  endfunction

  assign mux_out = mux_in(sel);

  rr_mux_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_out   (mux_out),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One cycle: apply inputs, predict the grant from the model, then advance.
  task automatic step(input logic [3:0] r, input logic rdy);
    int win;
    bit found;
    bit any;
    bit acc;
    req       = r;
    out_ready = rdy;
    #1;
    any   = (r != 4'b0000);
    win   = m_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (!found && r[c]) begin
        win   = c;
        found = 1'b1;
      end
    end
    acc = any && (!m_full || rdy);
    check("sel", sel, any ? win : m_ptr);
    check("gnt", gnt, acc ? (1 << win) : 0);
    if (acc) sb.push_back('{mux_in(2'(win)), 2'(win)});
    @(posedge clk);
    #1;
    if (acc) begin
      m_ptr  = (win + 1) % 4;
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endtask

  // Asynchronous reset asserted between edges; checks effect before any edge.
  task automatic do_reset(input logic [3:0] r);
    req = r;
    rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_gnt", gnt, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    if (r == 4'b0000) check("rst_sel", sel, 0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_gnt_hold", gnt, 0);
    check("rst_valid_hold", out_valid, 0);
    rst = 1'b0;
  endtask

  // Monitor: output register content must match the oldest pending word.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, m_full);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          check("out_data", out_data, sb[0].d);
          check("out_ch", out_ch, sb[0].ch);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset(4'b1111);
    // rotation over all four channels
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1);
    // two alternating requesters
    for (int i = 0; i < 6; i++) step(4'b1010, 1'b1);
    step(4'b0000, 1'b1);
    // backpressure then same-cycle drain-and-refill
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    // single pulse from empty, then idle
    do_reset(4'b0000);
    step(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    // pointer wrap after ch3
    step(4'b1000, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b1);
    // reset while full
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    do_reset(4'b0110);
    step(4'b0110, 1'b1);
    step(4'b0000, 1'b1);
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic       rdy;
      r   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset(r);
      else step(r, rdy);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and output register for the 4-to-1 byte multiplexer. It takes four per-channel request lines and drives the multiplexer's 2-bit `sel`. When it grants a channel, it captures the multiplexer's output into a single-entry output register. That register drains through a valid/ready handshake to the next stage. The multiplexer stays purely combinational; all sequencing, fairness and flow control live in this block.

## Interface
- `WIDTH`, default 8: data width; must match the multiplexer data width.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  4: per-channel request, level-sensitive. Channel i holds `req[i]` high, with its multiplexer input stable, until it sees `gnt[i]`.
- `mux_out`  input  WIDTH: the multiplexer's `out`, returned to this block.
- `sel`  output  2: select for the multiplexer; combinational.
- `gnt`  output  4: one-hot transfer strobe; `gnt[i]`=1 means channel i is accepted at this clock edge; combinational.
- `out_data`  output  WIDTH: registered data.
- `out_ch`  output  2: source channel of `out_data`.
- `out_valid`  output  1: `out_data`/`out_ch` hold a valid word.
- `out_ready`  input  1: downstream accepts the word when `out_valid` and `out_ready` are both 1 at an edge.

## Operation
- State register, two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Round-robin pointer `ptr[1:0]`: the highest-priority channel for the next arbitration.
- Winner: the first channel with `req` high, scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (all mod 4).
- `any_req` = OR of `req`.
- `sel` = winner index when `any_req`=1, else `ptr`.
- `can_accept` = EMPTY, or (FULL and `out_ready`=1).
- `accept` = `can_accept` and `any_req`.
- `gnt` = one-hot(winner) when `accept`=1, else 4'b0000. At most one bit of `gnt` is ever set.
- On an `accept` edge:
  - `out_data` <= `mux_out`; `out_ch` <= winner; state <= FULL.
  - `ptr` <= winner+1 mod 4 (3 wraps to 0).
- FULL with `out_ready`=1 and `any_req`=0: state <= EMPTY. `out_data`/`out_ch` keep their last values.
- FULL with `out_ready`=0: everything holds, `gnt`=0 (backpressure). `sel` keeps tracking the current winner.
- EMPTY with `any_req`=0: nothing changes.
- `ptr` changes only on `accept`. Idle cycles and stalls do not rotate priority.
- Fairness: a continuously requesting channel is granted within 4 accepts.
- Reset values, asserted asynchronously and held while `rst`=1:
  - state=EMPTY, `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0.
  - `gnt` is forced to 0 while `rst`=1, whatever `req` is.
  - `sel`=0 when `req`=0.
- Reset mid-operation discards any word held in the output register and restarts priority at channel 0.
- A request dropped before its grant is simply lost to arbitration; no error flag.

## Timing
- Grant latency: 0 cycles. `gnt`/`sel` respond combinationally to `req`, `ptr`, state and `out_ready` in the same cycle.
- Data latency: channel granted at edge n → `out_valid`=1, `out_data`=that channel's data and `out_ch` valid from edge n onward (visible in cycle n+1).
- Throughput: one word per clock while `out_ready`=1 and any request is present. The same-cycle drain-and-refill leaves no bubble.
- Combinational path: `req` → `sel` → multiplexer → `mux_out` → `out_data` D-input. It must close within one clock.
- `out_ready` may change any cycle. `out_valid`/`out_data` must not change while stalled.
- Deassertion of `rst` is synchronised externally. The first possible grant is at the first edge after release.

## Test plan
- Test multiplexer inputs: in0=8'hAA, in1=8'hB1, in2=8'hC2, in3=8'hD3.
1. Reset while `req`=4'b1111: `out_valid`=0, `out_data`=8'h00, `gnt`=0. After release with `out_ready`=1, the first grants go to ch0, 1, 2, 3, 0 on consecutive edges. `out_data` = AA, B1, C2, D3, AA; `out_ch` = 0, 1, 2, 3, 0.
2. `req`=4'b1010, `out_ready`=1: grants alternate ch1, ch3, ch1, and so on. `sel` alternates 1, 3. `out_data` alternates B1, D3.
3. Backpressure, `req`=4'b0100, `out_ready`=0: one grant (C2, `out_valid`=1), then `gnt`=0 and `out_data` holds C2 for 5 cycles. Raising `out_ready` gives a second C2 grant in the same cycle, with no bubble.
4. Single request `req`=4'b0001 pulsed for one cycle while EMPTY: `gnt`=4'b0001 that cycle. `out_valid`=1 with AA for one cycle (`out_ready`=1), then EMPTY. `ptr`=1, `sel`=1 while idle.
5. Wrap and fairness: after a ch3 grant (`ptr` wraps to 0), assert `req`=4'b1001. Ch0 is granted next, then ch3.
6. Async reset mid-stream: assert `rst` between edges while FULL. `out_valid` drops immediately without a clock edge, the held word is lost, and after release the first grant goes to the lowest requesting channel from 0.
